// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: configures a uart_16750 over its register bus, then polls LSR to move bytes
// between the UART and valid/ready streams, counting line errors and flagging a match character.
module uart_host_ctrl #(
  parameter logic [15:0] DIVISOR    = 16'h0011,
  parameter logic [7:0]  LCR_CFG    = 8'h03,
  parameter logic [7:0]  FCR_CFG    = 8'h00,
  parameter logic [7:0]  IER_CFG    = 8'h03,
  parameter int          POLL_GAP   = 0,
  parameter logic [7:0]  MATCH_CHAR = 8'h20,
  parameter int          ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             uart_cs,
  output logic             uart_wr,
  output logic             uart_rd,
  output logic [2:0]       uart_addr,
  output logic [7:0]       uart_din,
  input  logic [7:0]       uart_dout,
  input  logic             cfg_start,
  output logic             cfg_done,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic [ERR_W-1:0] err_count,
  output logic             match
);
  typedef enum logic [2:0] {S_CFG, S_WAIT, S_LSR, S_RBR, S_THR} state_t;
  localparam logic [7:0] GAP_M1 = 8'(POLL_GAP - 1);
  state_t r_st, w_nx, w_back;
  logic [1:0] r_ph;
  logic [2:0] r_step, w_cfg_addr;
  logic [7:0] r_gap, r_tx, w_cfg_din;
  logic [5:0] r_lsr;
  logic r_pend, r_cfg_done, r_rx_valid, r_match;
  logic [7:0] r_rx_data;
  logic [ERR_W-1:0] r_err;
  logic w_rd_acc, w_wr_acc, w_last, w_dec, w_rx_go, w_tx_go;
  logic w_cs, w_wr, w_rd;
  logic [2:0] w_addr;
  logic [7:0] w_din;
  assign w_rd_acc = (r_st == S_LSR) || (r_st == S_RBR);
  assign w_wr_acc = (r_st == S_CFG) || (r_st == S_THR);
  assign w_last   = w_rd_acc ? (r_ph == 2'd3) : (r_ph == 2'd2);
  assign w_dec    = (r_st == S_LSR) && (r_ph == 2'd3);
  assign w_rx_go  = r_lsr[0] & ~r_rx_valid;
  assign w_tx_go  = ~w_rx_go & r_lsr[5] & tx_valid & r_cfg_done;
  assign w_back   = r_pend ? S_CFG : (POLL_GAP == 0 ? S_LSR : S_WAIT);
  always_comb begin
    w_cfg_addr = 3'd1;
    w_cfg_din  = IER_CFG;
    case (r_step)
      3'd0:    begin w_cfg_addr = 3'd3; w_cfg_din = LCR_CFG | 8'h80; end
      3'd1:    begin w_cfg_addr = 3'd0; w_cfg_din = DIVISOR[7:0];    end
      3'd2:    begin w_cfg_addr = 3'd1; w_cfg_din = DIVISOR[15:8];   end
      3'd3:    begin w_cfg_addr = 3'd3; w_cfg_din = LCR_CFG & 8'h7F; end
      3'd4:    begin w_cfg_addr = 3'd2; w_cfg_din = FCR_CFG;         end
      default: begin w_cfg_addr = 3'd1; w_cfg_din = IER_CFG;         end
    endcase
  end
  always_comb begin
    w_nx = r_st;
    case (r_st)
      S_CFG:   if (w_last && r_step == 3'd5) w_nx = (POLL_GAP == 0) ? S_LSR : S_WAIT;
      S_WAIT:  w_nx = r_pend ? S_CFG : (r_gap == GAP_M1 ? S_LSR : S_WAIT);
      S_LSR:   if (w_last) w_nx = w_rx_go ? S_RBR : (w_tx_go ? S_THR : w_back);
      default: if (w_last) w_nx = w_back;
    endcase
  end
  assign w_cs   = w_wr_acc ? (r_ph < 2'd2) : (w_rd_acc && r_ph < 2'd3);
  assign w_wr   = w_wr_acc && r_ph == 2'd1;
  assign w_rd   = w_rd_acc && (r_ph == 2'd1 || r_ph == 2'd2);
  assign w_addr = (r_st == S_CFG) ? w_cfg_addr : (r_st == S_LSR ? 3'd5 : 3'd0);
  assign w_din  = (r_st == S_CFG) ? w_cfg_din : (r_st == S_THR ? r_tx : 8'h00);
  // Gate with rst so the bus goes quiet the instant reset asserts, not at the next edge.
  assign uart_cs   = w_cs & ~rst;
  assign uart_wr   = w_wr & ~rst;
  assign uart_rd   = w_rd & ~rst;
  assign uart_addr = rst ? 3'd0 : w_addr;
  assign uart_din  = rst ? 8'h00 : w_din;
  assign tx_ready  = w_dec & w_tx_go;
  assign cfg_done  = r_cfg_done;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign err_count = r_err;
  assign match     = r_match;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st       <= S_CFG;
      r_ph       <= 2'd0;
      r_step     <= 3'd0;
      r_gap      <= 8'd0;
      r_tx       <= 8'd0;
      r_lsr      <= 6'd0;
      r_pend     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_match    <= 1'b0;
      r_err      <= '0;
    end else begin
      r_st       <= w_nx;
      r_ph       <= (r_st == S_WAIT || w_last) ? 2'd0 : r_ph + 2'd1;
      r_step     <= (r_st != S_CFG) ? 3'd0 : r_step + {2'd0, w_last};
      r_gap      <= (r_st == S_WAIT) ? r_gap + 8'd1 : 8'd0;
      r_pend     <= (w_nx == S_CFG) ? 1'b0 : (r_pend | (cfg_start & (r_st != S_CFG)));
      r_cfg_done <= (w_nx != S_CFG);
      r_rx_valid <= ((r_st == S_RBR) && r_ph == 2'd2) | (r_rx_valid & ~rx_ready);
      if (r_st == S_LSR && r_ph == 2'd2) r_lsr <= uart_dout[5:0];
      if (tx_ready) r_tx <= tx_data;
      if (r_st == S_RBR && r_ph == 2'd2) begin
        r_rx_data <= uart_dout;
        r_match   <= (uart_dout == MATCH_CHAR);
      end
      if (w_dec && |r_lsr[4:1] && ~&r_err) r_err <= r_err + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: directed bench with a write scoreboard; a tiny UART register model answers
// LSR/RBR reads while every bus write is popped against the expected queue.
module tb_uart_host_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic uart_cs, uart_wr, uart_rd, cfg_start, cfg_done, tx_valid, tx_ready, rx_valid, rx_ready, match;
  logic [2:0] uart_addr;
  logic [7:0] uart_din, uart_dout, tx_data, rx_data, err_count;
  logic [7:0] lsr_val = 8'h00, rbr_val = 8'h00;
  logic [10:0] exp_q[$];
  int passed = 0, total = 0, fails = 0;
  int tx_pulses = 0, rbr_rd = 0, lsr_dec = 0, n_wr = 0;
  uart_host_ctrl dut (
    .clk(clk), .rst(rst), .uart_cs(uart_cs), .uart_wr(uart_wr), .uart_rd(uart_rd),
    .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout), .cfg_start(cfg_start),
    .cfg_done(cfg_done), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .err_count(err_count), .match(match)
  );
  always #5 clk = ~clk;
  assign uart_dout = (uart_addr == 3'd5) ? lsr_val : (uart_addr == 3'd0) ? rbr_val : 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_tx_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, tx_ready}, 1);
  endtask
  task automatic wait_dec();
    int c = lsr_dec;
    int n = 0;
    do begin
      tick();
      n++;
    end while (lsr_dec == c && n < 20);
    if (n >= 20) chk("lsr_poll_timeout", lsr_dec - c, 1);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_ready) begin
        tx_pulses++;
        chk("tx_ready_cfg_done", {31'd0, cfg_done}, 1);
      end
      if (uart_cs && uart_rd && uart_addr == 3'd0) rbr_rd++;
      if (uart_addr == 3'd5 && !uart_cs) lsr_dec++;
      if (uart_cs && uart_wr) begin
        n_wr++;
        chk("wr_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) chk("wr_bus", {21'd0, uart_addr, uart_din}, {21'd0, exp_q.pop_front()});
      end
    end
  end
  initial begin
    int n, p0, w0, r0;
    cfg_start = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
    repeat (3) tick();
    chk("rst_bus", {uart_cs, uart_wr, uart_rd, uart_addr, uart_din}, 0);
    chk("rst_flags", {cfg_done, tx_ready, rx_valid, match, rx_data, err_count}, 0);
    exp_q.push_back({3'd3, 8'h83}); exp_q.push_back({3'd0, 8'h11}); exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd3, 8'h03}); exp_q.push_back({3'd2, 8'h00}); exp_q.push_back({3'd1, 8'h03});
    rst = 0;
    #1;
    chk("cfg_w1", {uart_cs, uart_wr, uart_rd, uart_addr, uart_din}, {1'b1, 1'b0, 1'b0, 3'd3, 8'h83});
    n = 0;
    while (!cfg_done && n < 40) begin
      tick();
      n++;
    end
    chk("cfg_done_cycle", n + 1, 19);
    chk("cfg_q_empty", exp_q.size(), 0);
    // tx byte through THR
    lsr_val = 8'h60; tx_data = 8'h41; tx_valid = 1; p0 = tx_pulses;
    exp_q.push_back({3'd0, 8'h41});
    wait_tx_ready("tx_ready_seen");
    tick();
    tx_valid = 0; tx_data = 8'h99;
    chk("thr_w1", {uart_cs, uart_wr, uart_rd, uart_addr, uart_din}, {1'b1, 1'b0, 1'b0, 3'd0, 8'h41});
    tick();
    chk("thr_w2", {uart_cs, uart_wr, uart_rd, uart_addr, uart_din}, {1'b1, 1'b1, 1'b0, 3'd0, 8'h41});
    tick();
    chk("thr_w3", {uart_cs, uart_wr, uart_rd, uart_addr, uart_din}, {1'b0, 1'b0, 1'b0, 3'd0, 8'h41});
    repeat (10) tick();
    chk("tx_one_pulse", tx_pulses - p0, 1);
    chk("tx_q_empty", exp_q.size(), 0);
    // rx has priority over tx
    lsr_val = 8'h61; rbr_val = 8'h20;
    wait_dec();
    tx_valid = 1; tx_data = 8'h55; w0 = n_wr; p0 = tx_pulses;
    n = 0;
    while (!rx_valid && n < 40) begin
      tick();
      n++;
    end
    chk("rx_valid_set", {31'd0, rx_valid}, 1);
    chk("rx_data", {24'd0, rx_data}, 32'h20);
    chk("rx_match", {31'd0, match}, 1);
    chk("no_thr_with_rx", n_wr - w0, 0);
    chk("no_tx_ready_with_rx", tx_pulses - p0, 0);
    // held rx byte blocks RBR reads; tx proceeds instead
    exp_q.push_back({3'd0, 8'h55}); r0 = rbr_rd;
    wait_tx_ready("tx_while_rx_held");
    tick();
    tx_valid = 0; lsr_val = 8'h00;
    repeat (10) tick();
    chk("no_rbr_read", rbr_rd - r0, 0);
    chk("rx_held", {rx_valid, rx_data}, {1'b1, 8'h20});
    chk("held_q_empty", exp_q.size(), 0);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    chk("rx_consumed", {rx_valid, rx_data, match}, {1'b0, 8'h20, 1'b1});
    // error counting and saturation
    wait_dec();
    lsr_val = 8'h62;
    for (int k = 1; k <= 300; k++) begin
      wait_dec();
      tick();
      if (k == 100 || k == 255 || k == 256 || k == 300) chk("err_count", {24'd0, err_count}, k > 255 ? 255 : k);
    end
    // cfg_start mid write: write finishes, then full reconfiguration
    lsr_val = 8'h60; tx_valid = 1; tx_data = 8'hA5;
    exp_q.push_back({3'd0, 8'hA5});
    exp_q.push_back({3'd3, 8'h83}); exp_q.push_back({3'd0, 8'h11}); exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd3, 8'h03}); exp_q.push_back({3'd2, 8'h00}); exp_q.push_back({3'd1, 8'h03});
    wait_tx_ready("tx_before_restart");
    tick();
    tx_valid = 0; lsr_val = 8'h00; cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("restart_w2", {uart_cs, uart_wr, uart_addr, uart_din, cfg_done}, {1'b1, 1'b1, 3'd0, 8'hA5, 1'b1});
    n = 0;
    while (cfg_done && n < 10) begin
      tick();
      n++;
    end
    chk("cfg_done_drop", {31'd0, cfg_done}, 0);
    n = 0;
    while (!cfg_done && n < 40) begin
      tick();
      n++;
    end
    chk("recfg_cycles", n, 18);
    chk("recfg_q_empty", exp_q.size(), 0);
    chk("state_kept", {rx_data, err_count}, {8'h20, 8'hFF});
    // reset in the middle of a read strobe
    n = 0;
    while (!(uart_cs && uart_rd && uart_addr == 3'd5) && n < 20) begin
      tick();
      n++;
    end
    chk("found_lsr_r2", {uart_cs, uart_rd, uart_addr}, {1'b1, 1'b1, 3'd5});
    rst = 1;
    #1;
    chk("rst_abort", {uart_cs, uart_wr, uart_rd, cfg_done, rx_valid, err_count}, 0);
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
